// File: rtl/freq_meter_if.sv
// Bus between the frequency meter and its consumer: control/signal inputs and the measured results.
// With FREQ_METER_PERIOD_EN defined, the rise-to-rise period outputs are also carried.
interface freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] freq_cnt;
  logic             cnt_valid;
  logic             ovf;
  logic             busy;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0]      period_cyc;
  logic             period_valid;

  modport master (
    output enable, sig_in,
    input  freq_cnt, cnt_valid, ovf, busy, period_cyc, period_valid
  );
  modport slave (
    input  enable, sig_in,
    output freq_cnt, cnt_valid, ovf, busy, period_cyc, period_valid
  );
`else
  modport master (
    output enable, sig_in,
    input  freq_cnt, cnt_valid, ovf, busy
  );
  modport slave (
    input  enable, sig_in,
    output freq_cnt, cnt_valid, ovf, busy
  );
`endif
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over back-to-back windows of GATE_CYCLES clocks and reports each result.
// Optional macro FREQ_METER_PERIOD_EN adds a saturating rise-to-rise period measurement.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  freq_meter_if.slave bus
);

  localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GATE = 1'b1;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;

  logic [0:0]       state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;

  logic             at_max;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;
  logic             terminal;

  // s1 is the metastability stage; s3 only serves as the previous value of s2 for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  assign at_max    = &edge_cnt;
  assign edge_next = (rise && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign sat_next  = sat | (rise & at_max);
  assign terminal  = (state == ST_GATE) && (gate_cnt == GATE_LAST);

  // Terminal cycle wins over a falling enable, so a window that reaches its end is always reported
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (bus.enable) begin
            state <= ST_GATE;
          end
        end
        ST_GATE: begin
          if (terminal) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            if (!bus.enable) begin
              state <= ST_IDLE;
            end
          end else if (!bus.enable) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_next;
            sat      <= sat_next;
          end
        end
        default: begin
          state    <= ST_IDLE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
        end
      endcase
    end
  end

  // Results only move on a completed window; aborts leave the previous report in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.freq_cnt  <= '0;
      bus.ovf       <= 1'b0;
      bus.cnt_valid <= 1'b0;
    end else begin
      bus.cnt_valid <= terminal;
      if (terminal) begin
        bus.freq_cnt <= edge_next;
        bus.ovf      <= sat_next;
      end
    end
  end

  assign bus.busy = (state == ST_GATE);

`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] run_cnt;
  logic        have_prev;

  // run_cnt counts clocks since the last rise; the period is that count plus the rise cycle itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt          <= '0;
      have_prev        <= 1'b0;
      bus.period_cyc   <= '0;
      bus.period_valid <= 1'b0;
    end else begin
      bus.period_valid <= 1'b0;
      if (!bus.enable) begin
        run_cnt   <= '0;
        have_prev <= 1'b0;
      end else if (rise) begin
        run_cnt   <= '0;
        have_prev <= 1'b1;
        if (have_prev) begin
          bus.period_valid <= 1'b1;
          bus.period_cyc   <= (&run_cnt) ? run_cnt : run_cnt + 32'd1;
        end
      end else if (!(&run_cnt)) begin
        run_cnt <= run_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYCLES=100, CNT_W=5): window-level reference model,
// a table of steady-state patterns, hand-written abort/reset sequences and randomized stimulus.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int W    = 5;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  freq_meter_if #(.CNT_W(W)) bus ();

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a rise on sig_in as sampled at edge k is counted at edge k+2 (edge-detect delay),
  // a window opens on the edge enable is seen in idle and closes exactly G edges later.
  bit hist[$] = '{0, 0, 0, 0};
  int cyc = 0;
  bit in_win = 0;
  int win_start = 0;
  int acc = 0;
  int m_freq = 0;
  bit m_ovf = 0;
  bit m_valid = 0;
  int valid_seen = 0;
  int last_vfreq = 0;
  bit last_vovf = 0;
`ifdef FREQ_METER_PERIOD_EN
  bit      have_prev = 0;
  int      prev_rise = 0;
  longint  m_pc = 0;
  bit      m_pv = 0;
  int      last_pc = 0;
  int      pv_seen = 0;
`endif

  always @(posedge clk) begin
    bit r;
    bit en;
    cyc++;
    en      = bus.enable;
    m_valid = 0;
`ifdef FREQ_METER_PERIOD_EN
    m_pv = 0;
`endif
    if (rst) begin
      hist   = '{0, 0, 0, 0};
      in_win = 0;
      acc    = 0;
      m_freq = 0;
      m_ovf  = 0;
`ifdef FREQ_METER_PERIOD_EN
      have_prev = 0;
      m_pc      = 0;
`endif
    end else begin
      hist.push_front(bus.sig_in);
      void'(hist.pop_back());
      r = hist[2] & ~hist[3];
      if (in_win) begin
        acc += int'(r);
        if (cyc == win_start + G) begin
          m_valid = 1;
          m_freq  = (acc > MAXC) ? MAXC : acc;
          m_ovf   = (acc > MAXC);
          acc     = 0;
          if (en) win_start = cyc;
          else    in_win = 0;
        end else if (!en) begin
          in_win = 0;
          acc    = 0;
        end
      end else if (en) begin
        in_win    = 1;
        win_start = cyc;
        acc       = 0;
      end
`ifdef FREQ_METER_PERIOD_EN
      if (!en) begin
        have_prev = 0;
      end else if (r) begin
        if (have_prev) begin
          m_pv = 1;
          m_pc = cyc - prev_rise;
        end
        have_prev = 1;
        prev_rise = cyc;
      end
`endif
    end
    #1;
    checkOutput("busy", bus.busy, in_win);
    checkOutput("cnt_valid", bus.cnt_valid, m_valid);
    checkOutput("freq_cnt", bus.freq_cnt, m_freq);
    checkOutput("ovf", bus.ovf, m_ovf);
    if (bus.cnt_valid === 1'b1) begin
      valid_seen++;
      last_vfreq = int'(bus.freq_cnt);
      last_vovf  = bus.ovf;
    end
`ifdef FREQ_METER_PERIOD_EN
    checkOutput("period_valid", bus.period_valid, m_pv);
    checkOutput("period_cyc", bus.period_cyc, m_pc);
    if (bus.period_valid === 1'b1) begin
      pv_seen++;
      last_pc = int'(bus.period_cyc);
    end
`endif
  end

  int ph = 0;

  task automatic applyStimulus(input int half, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      ph++;
      if (ph >= half) begin
        ph = 0;
        bus.sig_in = ~bus.sig_in;
      end
    end
  endtask

  task automatic waitValid(output int k);
    k = 0;
    for (int i = 1; i <= 3 * G; i++) begin
      @(posedge clk);
      #2;
      if (bus.cnt_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    int half;
    int exp_freq;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int seen0;
    int k;
    int hold;

    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen0;
    int k;
    int hold;

    tbl[0] = '{half: 5,  exp_freq: 10, exp_ovf: 1'b0};
    tbl[1] = '{half: 1,  exp_freq: 31, exp_ovf: 1'b1};
    tbl[2] = '{half: 5,  exp_freq: 10, exp_ovf: 1'b0};
    tbl[3] = '{half: 2,  exp_freq: 25, exp_ovf: 1'b0};
    tbl[4] = '{half: 10, exp_freq: 5,  exp_ovf: 1'b0};
    tbl[5] = '{half: 50, exp_freq: 1,  exp_ovf: 1'b0};
    tbl[6] = '{half: 5,  exp_freq: 10, exp_ovf: 1'b0};

    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with enable low: nothing should happen
    applyStimulus(3, 50);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_valids", valid_seen, 0);
    checkOutput("idle_freq", bus.freq_cnt, 0);
    checkOutput("idle_ovf", bus.ovf, 0);

    // Steady-state patterns, each checked on a window well after the switch
    bus.enable = 1'b1;
    foreach (tbl[i]) begin
      seen0 = valid_seen;
      applyStimulus(tbl[i].half, 3 * G);
      checkOutput($sformatf("tbl%0d_valids", i), (valid_seen - seen0) >= 2, 1);
      checkOutput($sformatf("tbl%0d_freq", i), last_vfreq, tbl[i].exp_freq);
      checkOutput($sformatf("tbl%0d_ovf", i), last_vovf, tbl[i].exp_ovf);
    end

    // Abort at gate_cnt=40: no report, previous result held
    bus.enable = 1'b0;
    applyStimulus(5, 20);
    bus.enable = 1'b1;
    applyStimulus(5, 41);
    bus.enable = 1'b0;
    seen0 = valid_seen;
    @(posedge clk);
    #2;
    checkOutput("abort_busy", bus.busy, 0);
    applyStimulus(5, 30);
    checkOutput("abort_no_valid", valid_seen - seen0, 0);
    checkOutput("abort_hold_freq", bus.freq_cnt, 10);
    checkOutput("abort_hold_ovf", bus.ovf, 0);

    bus.enable = 1'b1;
    waitValid(k);
    checkOutput("reenable_latency", k, G + 1);

    // Reset at gate_cnt=60 of a window following a reported one
    applyStimulus(5, G + 61);
    rst = 1'b1;
    #1;
    checkOutput("rst_freq", bus.freq_cnt, 0);
    checkOutput("rst_valid", bus.cnt_valid, 0);
    checkOutput("rst_ovf", bus.ovf, 0);
    checkOutput("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    waitValid(k);
    checkOutput("post_rst_latency", k, G + 1);

    // Randomized sig_in with occasional enable flips and reset pulses
    hold = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = 1'b0;
      hold--;
      if (hold <= 0) begin
        bus.sig_in = ~bus.sig_in;
        hold = int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;

`ifdef FREQ_METER_PERIOD_EN
    bus.enable = 1'b0;
    repeat (5) @(negedge clk);
    seen0 = pv_seen;
    bus.enable = 1'b1;
    applyStimulus(5, 300);
    checkOutput("period_pulses", (pv_seen - seen0) >= 25, 1);
    checkOutput("period_last", last_pc, 10);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
